// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline stage.
//   mem_ctrl_t   : {MemRead, MemWrite, RegWrite, MemtoReg}, MSB first
//   slot_t       : one stage entry at the default widths
//   capture_ctrl : clears RegWrite for writes aimed at r0
package pipe_pkg;

  localparam int unsigned CTRL_W     = 4;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  valid;
    mem_ctrl_t             ctrl;
    logic [DEF_REG_AW-1:0] wn;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] alu;
  } slot_t;

  // r0 is hard-wired to zero, so a write to it is never reported as a
  // register write downstream or to the forwarding logic.
  function automatic mem_ctrl_t capture_ctrl(input mem_ctrl_t c, input logic wn_is_r0);
    mem_ctrl_t r;
    r = c;
    if (wn_is_r0) r.reg_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register of the EX/MEM stage.
//   clk, reset : clock, synchronous active-high reset (zeroes everything)
//   clear      : synchronous kill, same effect as reset
//   load       : capture d_* and set valid
//   drop       : clear valid only; payload holds its last value
//   d_*        : payload inputs
//   q_*        : registered valid and payload
// Priority: reset/clear > load > drop.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  mem_ctrl_t         d_ctrl,
  input  logic [REG_AW-1:0] d_wn,
  input  logic [DATA_W-1:0] d_rd2,
  input  logic [DATA_W-1:0] d_alu,
  output logic              q_valid,
  output mem_ctrl_t         q_ctrl,
  output logic [REG_AW-1:0] q_wn,
  output logic [DATA_W-1:0] q_rd2,
  output logic [DATA_W-1:0] q_alu
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_wn    <= '0;
      q_rd2   <= '0;
      q_alu   <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_wn    <= d_wn;
      q_rd2   <= d_rd2;
      q_alu   <= d_alu;
    end else if (drop) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// Elastic EX/MEM pipeline stage with valid/ready on both sides.
//   clk, reset, flush   : clock, synchronous active-high reset, synchronous kill
//   in_valid / in_ready : EX-side handshake
//   *_in                : ALU result, store data, dest register, {MemRead,MemWrite,RegWrite,MemtoReg}
//   out_valid/out_ready : MEM-side handshake
//   *_out               : held entry; ctrl_out is zero whenever out_valid is low
//   fwd_*               : forwarding tap for the EX hazard unit
// SKID=1 adds a second slot so in_ready comes straight from a flop;
// SKID=0 uses one slot with a combinational in_ready.
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] rfile_rd2_in,
  input  logic [REG_AW-1:0] rfile_wn_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out_out,
  output logic [DATA_W-1:0] rfile_rd2_out,
  output logic [REG_AW-1:0] rfile_wn_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_wn,
  output logic [DATA_W-1:0] fwd_data
);

  logic              accept;
  mem_ctrl_t         cap_ctrl;

  logic              m_load, m_drop, m_sel_s;
  mem_ctrl_t         m_d_ctrl;
  logic [REG_AW-1:0] m_d_wn;
  logic [DATA_W-1:0] m_d_rd2, m_d_alu;
  logic              m_valid;
  mem_ctrl_t         m_ctrl;
  logic [REG_AW-1:0] m_wn;
  logic [DATA_W-1:0] m_rd2, m_alu;

  logic              s_valid;
  mem_ctrl_t         s_ctrl;
  logic [REG_AW-1:0] s_wn;
  logic [DATA_W-1:0] s_rd2, s_alu;

  assign accept = in_valid & in_ready;

  always_comb begin
    cap_ctrl = capture_ctrl(mem_ctrl_t'(ctrl_in), rfile_wn_in == '0);
  end

  // M is refilled either from S (older entry) or straight from EX.
  always_comb begin
    if (m_sel_s) begin
      m_d_ctrl = s_ctrl;
      m_d_wn   = s_wn;
      m_d_rd2  = s_rd2;
      m_d_alu  = s_alu;
    end else begin
      m_d_ctrl = cap_ctrl;
      m_d_wn   = rfile_wn_in;
      m_d_rd2  = rfile_rd2_in;
      m_d_alu  = alu_out_in;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_m (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (m_load),
    .drop    (m_drop),
    .d_ctrl  (m_d_ctrl),
    .d_wn    (m_d_wn),
    .d_rd2   (m_d_rd2),
    .d_alu   (m_d_alu),
    .q_valid (m_valid),
    .q_ctrl  (m_ctrl),
    .q_wn    (m_wn),
    .q_rd2   (m_rd2),
    .q_alu   (m_alu)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic m_free;
      logic s_load, s_drop;

      assign m_free = ~m_valid | out_ready;

      // S only ever holds an entry when M is full, so "S occupied" is the
      // same as "stage full"; in_ready is taken directly from the S flop.
      assign in_ready = ~s_valid;

      always_comb begin
        m_load  = 1'b0;
        m_drop  = 1'b0;
        m_sel_s = 1'b0;
        s_load  = 1'b0;
        s_drop  = 1'b0;
        if (m_free) begin
          if (s_valid) begin
            m_load  = 1'b1;
            m_sel_s = 1'b1;
            s_drop  = 1'b1;
            s_load  = accept;
          end else begin
            m_load  = accept;
            m_drop  = ~accept;
          end
        end else begin
          s_load = accept;
        end
      end

      pipe_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_s (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (s_load),
        .drop    (s_drop),
        .d_ctrl  (cap_ctrl),
        .d_wn    (rfile_wn_in),
        .d_rd2   (rfile_rd2_in),
        .d_alu   (alu_out_in),
        .q_valid (s_valid),
        .q_ctrl  (s_ctrl),
        .q_wn    (s_wn),
        .q_rd2   (s_rd2),
        .q_alu   (s_alu)
      );
    end else begin : g_noskid
      assign in_ready = ~m_valid | out_ready;
      assign s_valid  = 1'b0;
      assign s_ctrl   = '0;
      assign s_wn     = '0;
      assign s_rd2    = '0;
      assign s_alu    = '0;

      always_comb begin
        m_sel_s = 1'b0;
        m_load  = accept;
        m_drop  = m_valid & out_ready & ~accept;
      end
    end
  endgenerate

  assign out_valid     = m_valid;
  assign alu_out_out   = m_alu;
  assign rfile_rd2_out = m_rd2;
  assign rfile_wn_out  = m_wn;
  assign ctrl_out      = m_valid ? CTRL_W'(m_ctrl) : '0;
  assign fwd_valid     = m_valid & m_ctrl.reg_write;
  assign fwd_wn        = m_wn;
  assign fwd_data      = m_alu;

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Parametrised, elastic EX/MEM pipeline stage.
- Carries ALU result, store data, destination register and MEM/WB control bits from EX to MEM using valid/ready handshakes on both sides.
- Optional 2-entry skid buffer, so in_ready is registered and stalls do not create a combinational ready path back into EX.
- Adds flush, write-to-r0 suppression and a forwarding tap for the EX hazard unit.

Parameters:
DATA_W, 32, width of alu_out and store data
REG_AW, 5, register-file address width
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
flush  in  1  synchronous kill of all held entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept this cycle
alu_out_in  in  DATA_W  ALU result / address
rfile_rd2_in  in  DATA_W  store data
rfile_wn_in  in  REG_AW  destination register
ctrl_in  in  4  {MemRead, MemWrite, RegWrite, MemtoReg}
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM accepts this cycle
alu_out_out  out  DATA_W
rfile_rd2_out  out  DATA_W
rfile_wn_out  out  REG_AW
ctrl_out  out  4  same order as ctrl_in, gated by out_valid
fwd_valid  out  1  output entry valid and RegWrite=1
fwd_wn  out  REG_AW  = rfile_wn_out
fwd_data  out  DATA_W  = alu_out_out

Behaviour:
- Transfers:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready
- Capture rule: if rfile_wn_in == 0, the RegWrite bit is stored as 0. Other bits are stored unchanged.
- Storage: main slot M drives the outputs; skid slot S exists only when SKID=1. Each slot has a valid bit.
- SKID=1 rules:
  - in_ready is a registered signal equal to !S.valid.
  - M empty or drain, S valid: S moves to M. If accept in the same cycle, the input goes to S.
  - M empty or drain, S empty: the input (if accept) goes to M, else M.valid <= 0.
  - M full, no drain, accept: the input goes to S, and in_ready drops the next cycle.
  - Order is preserved at all times. No entry is dropped or duplicated.
- SKID=0 rules:
  - in_ready = !M.valid | out_ready (combinational).
  - On accept, M loads the input. On drain without accept, M.valid <= 0.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 per cycle when out_ready is held high.
- Output gating: ctrl_out = out_valid ? M.ctrl : 4'b0. A bubble never asserts MemRead, MemWrite or RegWrite.
- Data outputs hold their last value while out_valid = 0.
- Reset (and flush), both synchronous:
  - All valid bits, all data fields and all ctrl fields become 0.
  - out_valid = 0, ctrl_out = 0, alu_out_out = 0, rfile_rd2_out = 0, rfile_wn_out = 0, fwd_valid = 0.
  - in_ready = 1 in the following cycle.
- Priority: reset > flush > transfer.
  - Input presented in the flush cycle is dropped, even if accept is true.
  - Reset or flush during a stall discards both entries.
- Stall hold: while out_valid=1 and out_ready=0, every output is stable.
- Back-pressure: with SKID=1, at most one extra entry is accepted after out_ready falls.

Decomposition:
- Package pipe_pkg holds:
  - mem_ctrl_t packed struct {MemRead, MemWrite, RegWrite, MemtoReg}
  - CTRL_W = 4
  - default widths DATA_W=32, REG_AW=5
  - slot struct typedef {valid, ctrl, wn, rd2, alu}
- One sub-module, pipe_slot:
  - A single valid+payload register with load, clear and reset inputs.
  - Instantiated as M, and as S under SKID=1.

Test Plan:
1. Reset: reset=1 for 2 cycles with in_valid=1 -> all outputs 0; in_ready=1 after release.
2. Streaming, SKID=1: out_ready=1, accept alu_out_in = 0x10, 0x20, 0x30 with wn = 3, ctrl = 4'b0010 -> same values appear on consecutive cycles, each 1 cycle after accept.
3. Stall: out_ready=0 after entry 0x10 is in M; present 0x20 and 0x30.
   - 0x20 goes to S, in_ready drops next cycle, 0x30 is held by EX.
   - out_ready=1 -> outputs 0x10, 0x20, 0x30 in order.
4. Flush: flush=1 with M and S both full and in_valid=1 (0x40) -> next cycle out_valid=0, ctrl_out=0, all entries gone, 0x40 never appears.
5. r0 write: in_valid with wn=0, ctrl=4'b0011 -> ctrl_out=4'b0001, fwd_valid=0. The same instruction with wn=7 gives fwd_valid=1, fwd_wn=7.
6. SKID=0 build: out_ready=0 with M full -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> M replaced in 1 cycle with no bubble.
